// File: rtl/seq_multiplier_core.sv
// Unsigned shift-and-add multiplier: p = a * b over N iterations with a single 2N-bit adder.
// Latency: start accepted at edge k -> p and the done pulse are valid after edge k+N+1.
// Backpressure: none; start is ignored unless idle, with no queueing. One op per N+2 cycles.
module seq_multiplier_core #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2*N-1:0]  mcand;
    logic [2*N-1:0]  acc;
    logic [N-1:0]    mplier;
    logic [CW-1:0]   cnt;
    logic            last_iter;

    assign last_iter = (cnt == LAST_ITER);
    assign busy      = (state == CALC);

    // The reset input is active-high even though it is named resetn.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p only changes on completion, so it holds the last result across new starts.
    always_ff @(posedge clk) begin
        if (resetn) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            p      <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{N{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                DONE: begin
                    p    <= acc;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_core.sv
// Directed and randomized checks of seq_multiplier_core against a plain-arithmetic product model.
module tb_seq_multiplier_core;

    localparam int N      = 4;
    localparam int NPAIRS = 1 << (2 * N);

    logic           clk;
    logic           resetn;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    seq_multiplier_core #(.N(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .a      (a),
        .b      (b),
        .p      (p),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] product(input int x, input int y);
        return 32'(x * y);
    endfunction

    task automatic reset_pulse();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
    endtask

    // Issue one op, scramble operands after acceptance, then verify latency, busy time, result and pulse width.
    task automatic do_op(input int oa, input int ob);
        int   cyc;
        int   bc;
        logic seen;
        @(negedge clk);
        start = 1'b1;
        a     = N'(oa);
        b     = N'(ob);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        cyc   = 0;
        bc    = 0;
        seen  = 1'b0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (busy) bc++;
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency_edges", 32'(cyc - 1), 32'(N + 1));
        check("busy_cycles", 32'(bc), 32'(N));
        check("product", 32'(p), product(oa, ob));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("p_holds", 32'(p), product(oa, ob));
    endtask

    initial begin
        int order[NPAIRS];
        int tmp;
        int j;
        int cyc;
        int ndone;
        int first_done;
        int second_done;
        logic seen;

        resetn = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        check("reset_p", 32'(p), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Basic op, back-to-back variety, zero operands, max case
        do_op(14, 9);
        do_op(12, 2);
        do_op(6, 11);
        do_op(15, 15);
        do_op(0, 13);
        do_op(7, 0);

        // Start during CALC is ignored
        @(negedge clk);
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 4'd1;
        b     = 4'd1;
        ndone = 0;
        for (int c = 0; c < 3 * (N + 2); c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ignored_start_done_count", 32'(ndone), 32'd1);
        check("ignored_start_product", 32'(p), product(3, 5));

        // Reset mid-operation aborts and clears everything
        @(negedge clk);
        start = 1'b1;
        a     = 4'd15;
        b     = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        reset_pulse();
        check("abort_p", 32'(p), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int c = 0; c < 2 * (N + 2); c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        do_op(15, 15);

        // Start held high: a new op is accepted every N+2 cycles
        @(negedge clk);
        start       = 1'b1;
        a           = 4'd5;
        b           = 4'd7;
        first_done  = -1;
        second_done = -1;
        cyc         = 0;
        seen        = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                check("held_start_product", 32'(p), product(5, 7));
                if (first_done < 0) first_done = cyc;
                else begin
                    second_done = cyc;
                    seen        = 1'b1;
                end
            end
        end
        check("held_start_two_dones", 32'(seen), 32'd1);
        check("held_start_period", 32'(second_done - first_done), 32'(N + 2));
        start = 1'b0;
        repeat (2 * (N + 2)) @(negedge clk);

        // Every operand pair, in shuffled order with random idle gaps
        for (int i = 0; i < NPAIRS; i++) order[i] = i;
        for (int i = NPAIRS - 1; i > 0; i--) begin
            j        = $urandom_range(0, i);
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < NPAIRS; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(order[i] >> N, order[i] & ((1 << N) - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
